multi_channel_delay: RTL and testbench

Parametrised multi-channel programmable sample delay for the dedispersion path. Each of NUM_CH parallel frequency channels is delayed by its own runtime-programmable number of valid samples (0 to 2^ADDR_WIDTH-1). Storage is a per-channel circular RAM with a shared write pointer. The block sits between the channeliser output and the channel summer and replaces the single-channel FIFO delay.

---
 rtl/multi_channel_delay.sv | 99 +++++++++
 tb/tb_multi_channel_delay.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multi_channel_delay.sv
// Multi-channel programmable sample delay: per-channel circular RAM with shared write
// pointer, runtime delay registers, priming suppression and a zero-delay bypass.
module multi_channel_delay #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int CMD_WIDTH  = 32,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk_data,
   input  logic                         rst,
   input  logic                         delay_wr_en,
   input  logic [CH_W-1:0]              delay_wr_ch,
   input  logic [CMD_WIDTH-1:0]         delay_wr_val,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic                         data_in_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
   output logic                         data_out_valid,
   output logic                         delay_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] MAX_DLY  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [CMD_WIDTH-1:0]  MAX_CMD  = CMD_WIDTH'(DEPTH - 1);
   localparam logic [CH_W:0]         NUM_CH_L = (CH_W + 1)'(NUM_CH);

   function automatic logic [ADDR_WIDTH-1:0] clamp_delay(input logic [CMD_WIDTH-1:0] v);
      if (v > MAX_CMD) return MAX_DLY;
      else             return v[ADDR_WIDTH-1:0];
   endfunction

   logic [ADDR_WIDTH-1:0] r_delay [NUM_CH];
   logic [ADDR_WIDTH-1:0] r_wp;
   logic [ADDR_WIDTH-1:0] r_fill;
   logic                  r_vld_p1;
   logic                  r_err;
   logic [NUM_CH-1:0]     r_zero_p1;
   logic [NUM_CH-1:0]     r_byp_p1;
   logic                  w_wr;

   // RAM writes are held off during reset so a valid during rst has no effect.
   assign w_wr = data_in_valid & ~rst;

   always_ff @(posedge clk_data) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) r_delay[c] <= '0;
         r_wp      <= '0;
         r_fill    <= '0;
         r_vld_p1  <= 1'b0;
         r_err     <= 1'b0;
         r_zero_p1 <= '1;
         r_byp_p1  <= '0;
      end else begin
         r_vld_p1 <= data_in_valid;
         // p0 -> p1: select flags use the delay in force before any same-cycle write
         if (data_in_valid) begin
            r_wp <= r_wp + 1'b1;
            if (r_fill != MAX_DLY) r_fill <= r_fill + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
               r_zero_p1[c] <= (r_fill < r_delay[c]);
               r_byp_p1[c]  <= (r_delay[c] == '0);
            end
         end
         if (delay_wr_en) begin
            if ({1'b0, delay_wr_ch} >= NUM_CH_L) begin
               r_err <= 1'b1;
            end else begin
               r_delay[delay_wr_ch] <= clamp_delay(delay_wr_val);
               if (delay_wr_val > MAX_CMD) r_err <= 1'b1;
            end
         end
      end
   end

   assign data_out_valid = r_vld_p1;
   assign delay_err      = r_err;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [DATA_WIDTH-1:0] r_ram_q_p1;
      logic [DATA_WIDTH-1:0] r_byp_d_p1;
      logic [ADDR_WIDTH-1:0] w_ra;

      assign w_ra = r_wp - r_delay[c];

      // Read-before-write on the same port; delay 0 is served from the bypass register.
      always_ff @(posedge clk_data) begin
         if (w_wr) begin
            r_mem[r_wp] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
            r_ram_q_p1  <= r_mem[w_ra];
            r_byp_d_p1  <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      assign data_out[c*DATA_WIDTH +: DATA_WIDTH] =
         r_zero_p1[c] ? '0 : (r_byp_p1[c] ? r_byp_d_p1 : r_ram_q_p1);
   end

endmodule

// File: tb/tb_multi_channel_delay.sv
// Randomised bench for multi_channel_delay against a sample-history reference model.
module tb_multi_channel_delay;

   localparam int DW   = 16;
   localparam int NCH  = 3;
   localparam int AW   = 10;
   localparam int CW   = 32;
   localparam int CHW  = 2;
   localparam int MAXD = (1 << AW) - 1;
   localparam int HMAX = 8192;

   logic                clk_data = 1'b0;
   logic                rst;
   logic                delay_wr_en;
   logic [CHW-1:0]      delay_wr_ch;
   logic [CW-1:0]       delay_wr_val;
   logic [NCH*DW-1:0]   data_in;
   logic                data_in_valid;
   logic [NCH*DW-1:0]   data_out;
   logic                data_out_valid;
   logic                delay_err;

   multi_channel_delay #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW), .CMD_WIDTH(CW), .CH_W(CHW)
   ) dut (
      .clk_data      (clk_data),
      .rst           (rst),
      .delay_wr_en   (delay_wr_en),
      .delay_wr_ch   (delay_wr_ch),
      .delay_wr_val  (delay_wr_val),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .delay_err     (delay_err)
   );

   always #5 clk_data = ~clk_data;

   int n_chk = 0;
   int n_bad = 0;

   // Reference model: every valid sample since reset, indexed by its valid count.
   logic [DW-1:0] hist [NCH][HMAX];
   int            m_delay [NCH];
   int            m_k;
   logic [DW-1:0] exp_out [NCH];
   bit            exp_vld;
   bit            exp_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_delay[c] = 0;
         exp_out[c] = '0;
      end
      m_k     = 0;
      exp_vld = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic cyc(input bit r, input bit v, input bit we, input int ch, input int unsigned val);
      logic [NCH*DW-1:0] din;
      logic [NCH*DW-1:0] e;
      din           = NCH*DW'({$urandom, $urandom});
      rst           = r;
      data_in_valid = v;
      data_in       = din;
      delay_wr_en   = we;
      delay_wr_ch   = CHW'(ch);
      delay_wr_val  = val;
      if (r) begin
         model_reset();
      end else begin
         exp_vld = v;
         if (v) begin
            for (int c = 0; c < NCH; c++) begin
               if (m_k < HMAX) hist[c][m_k] = din[c*DW +: DW];
               if (m_k < m_delay[c]) exp_out[c] = '0;
               else if (m_k - m_delay[c] < HMAX) exp_out[c] = hist[c][m_k - m_delay[c]];
            end
            m_k++;
         end
         if (we) begin
            if (ch >= NCH) exp_err = 1'b1;
            else if (val > MAXD) begin
               m_delay[ch] = MAXD;
               exp_err     = 1'b1;
            end else m_delay[ch] = int'(val);
         end
      end
      @(posedge clk_data);
      #1;
      for (int c = 0; c < NCH; c++) e[c*DW +: DW] = exp_out[c];
      chk("valid", 64'(data_out_valid), 64'(exp_vld));
      chk("data_out", 64'(data_out), 64'(e));
      chk("delay_err", 64'(delay_err), 64'(exp_err));
   endtask

   task automatic samples(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; delay_wr_en = 1'b0; delay_wr_ch = '0; delay_wr_val = '0;
      data_in = '0; data_in_valid = 1'b0;
      model_reset();

      // reset defaults, then all-zero delays
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0);
      samples(10);

      // distinct per-channel delays including maximum, run past pointer wrap
      cyc(1'b0, 1'b0, 1'b1, 0, 1);
      cyc(1'b0, 1'b0, 1'b1, 1, 5);
      cyc(1'b0, 1'b0, 1'b1, 2, MAXD);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 0, 1);
      cyc(1'b0, 1'b0, 1'b1, 1, 5);
      cyc(1'b0, 1'b0, 1'b1, 2, MAXD);
      samples(1100);

      // gapped input
      cyc(1'b0, 1'b0, 1'b1, 1, 4);
      for (int i = 0; i < 200; i++) cyc(1'b0, ($urandom_range(0, 2) == 0), 1'b0, 0, 0);

      // delay change coincident with a valid sample, then random in-range changes
      cyc(1'b0, 1'b1, 1'b1, 2, 10);
      samples(12);
      cyc(1'b0, 1'b1, 1'b1, 2, 3);
      samples(3);
      cyc(1'b0, 1'b1, 1'b1, 2, 20);
      samples(5);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            cyc(1'b0, $urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, NCH - 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXD) : $urandom_range(0, 40));
         else
            cyc(1'b0, $urandom_range(0, 3) != 0, 1'b0, 0, 0);
      end

      // reset mid-stream: priming must hide stale RAM
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      for (int c = 0; c < NCH; c++) cyc(1'b0, 1'b0, 1'b1, c, 8);
      samples(50);
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      for (int c = 0; c < NCH; c++) cyc(1'b0, 1'b0, 1'b1, c, 8);
      samples(20);

      // oversize delay clamps and sets the sticky flag
      cyc(1'b0, 1'b1, 1'b1, 0, 5000);
      samples(30);
      cyc(1'b0, 1'b0, 1'b1, 1, 1023);
      samples(1030);

      // out-of-range channel after a clean reset
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 1, 2);
      samples(5);
      cyc(1'b0, 1'b1, 1'b1, 3, 7);
      samples(10);
      for (int i = 0; i < 100; i++)
         cyc(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3), $urandom_range(0, 2000));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
